uart_rx_core_p: RTL and testbench

//  Parametrised next-generation UART receive engine for the uart16650 tree.

---
 rtl/uart_rx_core_p_pkg.sv | 31 +++
 rtl/uart_rx_core_p_sampler.sv | 71 +++++++
 rtl/uart_rx_core_p.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_core_p.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_p_pkg.sv
// Shared definitions for the uart_rx_core_p receive engine.
//   - uart_rx_state_e : receiver FSM encodings (3 bits)
//   - UART_REC_*      : bit positions of the flag fields in a FIFO record
//   - clamp_char_len  : maps a programmed character length onto 5..data_max
package uart_rx_core_p_pkg;

  typedef enum logic [2:0] {
    UART_RX_ST_IDLE   = 3'd0,
    UART_RX_ST_START  = 3'd1,
    UART_RX_ST_DATA   = 3'd2,
    UART_RX_ST_PARITY = 3'd3,
    UART_RX_ST_STOP   = 3'd4,
    UART_RX_ST_HUNT   = 3'd5
  } uart_rx_state_e;

  // Record layout: {data[DATA_MAX-1:0], break, parity_err, framing_err}
  localparam int UART_REC_BI = 2;
  localparam int UART_REC_PE = 1;
  localparam int UART_REC_FE = 0;

  localparam int UART_CHAR_MIN = 5;

  // Lengths above the widest supported character clamp to it; lengths below
  // five are treated as five so the data phase never has zero bits.
  function automatic logic [3:0] clamp_char_len(input logic [3:0] len, input int data_max);
    if (int'(len) > data_max) return 4'(data_max);
    if (int'(len) < UART_CHAR_MIN) return 4'(UART_CHAR_MIN);
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_core_p_sampler.sv
// Intra-bit tick counter and three-point majority voter.
// Ports:
//   clk, wb_rst_i  clock, asynchronous active-high reset
//   enable_i       oversample tick
//   clear_i        synchronous flush (engine rx_reset)
//   go_i           from the FSM: this tick belongs to a frame and the bit
//                  timer should advance; when low the counter returns to 0
//   srx_i          serial input
//   mid_tick_o     tick OVS/2+1 of the bit (third sample taken, vote ready)
//   end_tick_o     last tick of the bit (OVS-1)
//   bit_val_o      majority of the samples at ticks OVS/2-1, OVS/2, OVS/2+1;
//                  valid while mid_tick_o is high (third sample is live srx_i)
module uart_rx_core_p_sampler
  import uart_rx_core_p_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic enable_i,
  input  logic clear_i,
  input  logic go_i,
  input  logic srx_i,
  output logic mid_tick_o,
  output logic end_tick_o,
  output logic bit_val_o
);

  localparam int CNT_W = $clog2(OVS);
  localparam logic [CNT_W-1:0] T_S0  = CNT_W'(OVS/2 - 1);
  localparam logic [CNT_W-1:0] T_S1  = CNT_W'(OVS/2);
  localparam logic [CNT_W-1:0] T_MID = CNT_W'(OVS/2 + 1);
  localparam logic [CNT_W-1:0] T_END = CNT_W'(OVS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;

  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    if (clear_i) begin
      cnt_d = '0;
      s0_d  = 1'b0;
      s1_d  = 1'b0;
    end else if (enable_i) begin
      if (go_i && (cnt_q != T_END)) cnt_d = cnt_q + 1'b1;
      else                          cnt_d = '0;
      if (cnt_q == T_S0) s0_d = srx_i;
      if (cnt_q == T_S1) s1_d = srx_i;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

  assign mid_tick_o = enable_i && (cnt_q == T_MID);
  assign end_tick_o = enable_i && (cnt_q == T_END);
  assign bit_val_o  = (s0_q & s1_q) | (s0_q & srx_i) | (s1_q & srx_i);

endmodule

// File: rtl/uart_rx_core_p.sv
// UART receive engine: oversampled start/data/parity/stop reception with
// majority-vote sampling and one-shot break detection.
// Ports:
//   clk, wb_rst_i        clock, asynchronous active-high reset
//   enable               oversample tick, OVS per bit time
//   rx_reset             synchronous flush, beats everything else
//   srx_pad_i            serial input (already synchronised)
//   char_len, parity_en, even_par, stick_par   line configuration
//   rf_push, rf_data_in  record output to the RX FIFO
//   rx_busy              FSM not in IDLE
//   rx_state_o           current FSM state (debug)
// Handshake: rf_push is a single-cycle strobe with rf_data_in valid in the
// same cycle; there is no ready, the FIFO must take every record.
module uart_rx_core_p
  import uart_rx_core_p_pkg::*;
#(
  parameter int OVS      = 16,
  parameter int DATA_MAX = 9
) (
  input  logic                clk,
  input  logic                wb_rst_i,
  input  logic                enable,
  input  logic                rx_reset,
  input  logic                srx_pad_i,
  input  logic [3:0]          char_len,
  input  logic                parity_en,
  input  logic                even_par,
  input  logic                stick_par,
  output logic                rf_push,
  output logic [DATA_MAX+2:0] rf_data_in,
  output logic                rx_busy,
  output logic [2:0]          rx_state_o
);

  localparam int REC_W = DATA_MAX + 3;
  localparam int BRK_W = $clog2(OVS * 12 + 1);

  uart_rx_state_e      state_q, state_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [DATA_MAX-1:0] data_q, data_d;
  logic [3:0]          len_q, len_d;
  logic                par_en_q, par_en_d;
  logic                even_q, even_d;
  logic                stick_q, stick_d;
  logic                pe_q, pe_d;
  logic                push_q, push_d;
  logic [REC_W-1:0]    rec_q, rec_d;
  logic [BRK_W-1:0]    brk_cnt_q, brk_cnt_d;
  logic                brk_hit_q, brk_hit_d;

  logic             go, brk_fire;
  logic             mid_tick, end_tick, bit_val;
  logic [3:0]       len_live;
  logic [BRK_W-1:0] brk_limit;

  uart_rx_core_p_sampler #(.OVS(OVS)) u_sampler (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .enable_i   (enable),
    .clear_i    (rx_reset),
    .go_i       (go),
    .srx_i      (srx_pad_i),
    .mid_tick_o (mid_tick),
    .end_tick_o (end_tick),
    .bit_val_o  (bit_val)
  );

  // Break limit follows the live configuration, not the latched frame copy.
  assign len_live  = clamp_char_len(char_len, DATA_MAX);
  assign brk_limit = BRK_W'(OVS * (2 + int'(len_live) + int'(parity_en)));

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    even_d    = even_q;
    stick_d   = stick_q;
    pe_d      = pe_q;
    push_d    = 1'b0;
    rec_d     = rec_q;
    brk_cnt_d = brk_cnt_q;
    brk_hit_d = brk_hit_q;
    go        = 1'b0;
    brk_fire  = 1'b0;

    if (rx_reset) begin
      state_d   = UART_RX_ST_IDLE;
      bit_idx_d = '0;
      data_d    = '0;
      len_d     = '0;
      par_en_d  = 1'b0;
      even_d    = 1'b0;
      stick_d   = 1'b0;
      pe_d      = 1'b0;
      rec_d     = '0;
      brk_cnt_d = '0;
      brk_hit_d = 1'b0;
    end else if (enable) begin
      // Consecutive-low counter; after it fires it holds until the line is high.
      if (srx_pad_i) begin
        brk_cnt_d = '0;
        brk_hit_d = 1'b0;
      end else if (!brk_hit_q) begin
        brk_cnt_d = brk_cnt_q + 1'b1;
        if (brk_cnt_d >= brk_limit) begin
          brk_hit_d = 1'b1;
          brk_fire  = 1'b1;
        end
      end

      case (state_q)
        UART_RX_ST_IDLE: begin
          if (!srx_pad_i) begin
            state_d   = UART_RX_ST_START;
            go        = 1'b1;
            bit_idx_d = '0;
            data_d    = '0;
            pe_d      = 1'b0;
            len_d     = len_live;
            par_en_d  = parity_en;
            even_d    = even_par;
            stick_d   = stick_par;
          end
        end
        UART_RX_ST_START: begin
          if (mid_tick && bit_val) begin
            state_d = UART_RX_ST_IDLE;
          end else begin
            go = 1'b1;
            if (end_tick) state_d = UART_RX_ST_DATA;
          end
        end
        UART_RX_ST_DATA: begin
          go = 1'b1;
          if (mid_tick) data_d[bit_idx_q] = bit_val;
          if (end_tick) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == len_q - 4'd1)
              state_d = par_en_q ? UART_RX_ST_PARITY : UART_RX_ST_STOP;
          end
        end
        UART_RX_ST_PARITY: begin
          go = 1'b1;
          if (mid_tick)
            pe_d = stick_q ? (bit_val != ~even_q)
                           : ((^{data_q, bit_val}) != ~even_q);
          if (end_tick) state_d = UART_RX_ST_STOP;
        end
        UART_RX_ST_STOP: begin
          if (mid_tick) begin
            push_d             = 1'b1;
            rec_d              = '0;
            rec_d[REC_W-1:3]   = data_q;
            rec_d[UART_REC_PE] = pe_q;
            rec_d[UART_REC_FE] = ~bit_val;
            // Resynchronise straight from mid-stop; a low stop needs the line high first.
            state_d = bit_val ? UART_RX_ST_IDLE : UART_RX_ST_HUNT;
          end else begin
            go = 1'b1;
          end
        end
        UART_RX_ST_HUNT: begin
          if (srx_pad_i) state_d = UART_RX_ST_IDLE;
        end
        default: state_d = UART_RX_ST_IDLE;
      endcase

      // Break overrides whatever the FSM decided on this tick, including a stop push.
      if (brk_fire) begin
        state_d            = UART_RX_ST_HUNT;
        go                 = 1'b0;
        push_d             = 1'b1;
        rec_d              = '0;
        rec_d[UART_REC_BI] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= UART_RX_ST_IDLE;
      bit_idx_q <= '0;
      data_q    <= '0;
      len_q     <= '0;
      par_en_q  <= 1'b0;
      even_q    <= 1'b0;
      stick_q   <= 1'b0;
      pe_q      <= 1'b0;
      push_q    <= 1'b0;
      rec_q     <= '0;
      brk_cnt_q <= '0;
      brk_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      even_q    <= even_d;
      stick_q   <= stick_d;
      pe_q      <= pe_d;
      push_q    <= push_d;
      rec_q     <= rec_d;
      brk_cnt_q <= brk_cnt_d;
      brk_hit_q <= brk_hit_d;
    end
  end

  assign rf_push    = push_q;
  assign rf_data_in = rec_q;
  assign rx_busy    = (state_q != UART_RX_ST_IDLE);
  assign rx_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_core_p.sv
// Testbench for uart_rx_core_p: serial frames are driven tick by tick, the
// expected records (value and arrival cycle) are queued by the driver from a
// frame-level model, and a negedge monitor pops and compares on every push.
module tb_uart_rx_core_p;

  localparam int OVS      = 16;
  localparam int DATA_MAX = 9;
  localparam int W        = DATA_MAX + 3;
  localparam int ENP      = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_HUNT  = 3'd5;

  logic         clk = 1'b0;
  logic         wb_rst_i;
  logic         enable;
  logic         rx_reset;
  logic         srx_pad_i;
  logic [3:0]   char_len;
  logic         parity_en;
  logic         even_par;
  logic         stick_par;
  logic         rf_push;
  logic [W-1:0] rf_data_in;
  logic         rx_busy;
  logic [2:0]   rx_state_o;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           checks  = 0;
  int           errors  = 0;
  int           cyc     = 0;
  int           low_run = 0;

  uart_rx_core_p #(.OVS(OVS), .DATA_MAX(DATA_MAX)) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .enable     (enable),
    .rx_reset   (rx_reset),
    .srx_pad_i  (srx_pad_i),
    .char_len   (char_len),
    .parity_en  (parity_en),
    .even_par   (even_par),
    .stick_par  (stick_par),
    .rf_push    (rf_push),
    .rf_data_in (rf_data_in),
    .rx_busy    (rx_busy),
    .rx_state_o (rx_state_o)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    enable = 1'b0;
    forever begin
      repeat (ENP - 1) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- checking helpers / model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_len();
    return (int'(char_len) > DATA_MAX) ? DATA_MAX : int'(char_len);
  endfunction

  function automatic int break_limit();
    return OVS * (2 + eff_len() + int'(parity_en));
  endfunction

  function automatic logic [W-1:0] char_record(input logic [8:0] d, input bit pe, input bit fe);
    return {d, 1'b0, pe, fe};
  endfunction

  // The record is registered on the tick edge and seen the cycle after it.
  task automatic expect_push(input logic [W-1:0] rec);
    exp_q.push_back(rec);
    exp_cyc_q.push_back(cyc);
  endtask

  // Waits for the next edge that consumes an oversample tick. The line model
  // tracks how long the line has been low; exactly the tick that makes the
  // low run equal the break length yields a break record.
  task automatic wait_tick();
    do @(posedge clk); while (enable !== 1'b1);
    #1;
    if (srx_pad_i == 1'b0) begin
      low_run++;
      if (low_run == break_limit()) expect_push({{DATA_MAX{1'b0}}, 3'b100});
    end else begin
      low_run = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic v, input int n, input bit glitch);
    for (int k = 0; k < n; k++) begin
      srx_pad_i = (glitch && k == OVS/2) ? ~v : v;
      wait_tick();
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input bit flip_par, input bit stop_val,
                            input int glitch_bit, input int lead);
    int         n;
    logic [9:0] m;
    logic [8:0] dm;
    logic       p;
    n  = eff_len();
    m  = (10'd1 << n) - 10'd1;
    dm = d & m[8:0];
    send_bit(1'b1, lead, 1'b0);
    send_bit(1'b0, OVS, 1'b0);
    for (int i = 0; i < n; i++) send_bit(dm[i], OVS, glitch_bit == i);
    if (parity_en) begin
      if (stick_par) p = ~even_par;
      else           p = even_par ? ^dm : ~^dm;
      send_bit(p ^ flip_par, OVS, 1'b0);
    end
    for (int k = 0; k < OVS; k++) begin
      srx_pad_i = stop_val;
      wait_tick();
      if (k == OVS/2 + 1) expect_push(char_record(dm, parity_en && flip_par, ~stop_val));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rf_push === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got record 0x%0h at cycle %0d, expected no push", rf_data_in, cyc);
      end else begin
        logic [W-1:0] er;
        int           ec;
        er = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("push_record", 32'(rf_data_in), 32'(er));
        check("push_cycle", cyc, ec);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] rd;
    int         gb;
    wb_rst_i  = 1'b1;
    rx_reset  = 1'b0;
    srx_pad_i = 1'b1;
    char_len  = 4'd8;
    parity_en = 1'b0;
    even_par  = 1'b0;
    stick_par = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rf_push", 32'(rf_push), 32'd0);
    check("reset_rf_data_in", 32'(rf_data_in), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    check("reset_state", 32'(rx_state_o), 32'(ST_IDLE));
    wb_rst_i = 1'b0;
    send_bit(1'b1, 8, 1'b0);

    // 8N1, 0xA5
    send_frame(9'h0A5, 1'b0, 1'b1, -1, 4);

    // 9E1, correct then flipped parity
    char_len  = 4'd9;
    parity_en = 1'b1;
    even_par  = 1'b1;
    send_frame(9'h1C3, 1'b0, 1'b1, -1, 3);
    send_frame(9'h1C3, 1'b1, 1'b1, -1, 3);

    // False start: 5 low ticks then high
    char_len  = 4'd8;
    parity_en = 1'b0;
    send_bit(1'b1, 4, 1'b0);
    send_bit(1'b0, 5, 1'b0);
    check("false_start_busy", 32'(rx_busy), 32'd1);
    check("false_start_state", 32'(rx_state_o), 32'(ST_START));
    send_bit(1'b1, OVS, 1'b0);
    check("false_start_idle", 32'(rx_busy), 32'd0);

    // Single-tick glitch at mid-bit of data bit 3 (and bit 4)
    send_frame(9'h0F0, 1'b0, 1'b1, 3, 2);
    send_frame(9'h0F0, 1'b0, 1'b1, 4, 2);

    // Low stop bit, then line held low for three character times
    send_frame(9'h000, 1'b0, 1'b0, -1, 2);
    check("stop_low_hunt", 32'(rx_state_o), 32'(ST_HUNT));
    send_bit(1'b0, 2 * 10 * OVS, 1'b0);
    check("break_hold_hunt", 32'(rx_state_o), 32'(ST_HUNT));
    send_frame(9'h03C, 1'b0, 1'b1, -1, 3);

    // rx_reset in the middle of a data bit
    send_bit(1'b1, 3, 1'b0);
    send_bit(1'b0, OVS, 1'b0);
    send_bit(1'b1, OVS, 1'b0);
    send_bit(1'b0, OVS, 1'b0);
    send_bit(1'b1, OVS/2, 1'b0);
    check("pre_rx_reset_state", 32'(rx_state_o), 32'(ST_DATA));
    rx_reset = 1'b1;
    @(posedge clk);
    #1;
    rx_reset = 1'b0;
    low_run  = 0;
    check("rx_reset_busy", 32'(rx_busy), 32'd0);
    check("rx_reset_state", 32'(rx_state_o), 32'(ST_IDLE));
    send_bit(1'b1, 2 * OVS, 1'b0);
    send_frame(9'h05A, 1'b0, 1'b1, -1, 2);

    // Asynchronous reset mid-frame
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b0, OVS, 1'b0);
    send_bit(1'b1, 5, 1'b0);
    #2;
    wb_rst_i  = 1'b1;
    srx_pad_i = 1'b1;
    #1;
    check("async_rst_rf_push", 32'(rf_push), 32'd0);
    check("async_rst_rf_data_in", 32'(rf_data_in), 32'd0);
    check("async_rst_busy", 32'(rx_busy), 32'd0);
    check("async_rst_state", 32'(rx_state_o), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    low_run  = 0;
    send_frame(9'h0C7, 1'b0, 1'b1, -1, 3);

    // Randomised frames with random configuration
    for (int f = 0; f < 24; f++) begin
      char_len  = 4'($urandom_range(5, 11));
      parity_en = 1'($urandom_range(0, 1));
      even_par  = 1'($urandom_range(0, 1));
      stick_par = 1'($urandom_range(0, 1));
      rd        = 9'($urandom);
      gb        = ($urandom_range(0, 1) == 1) ? $urandom_range(0, eff_len() - 1) : -1;
      send_frame(rd, $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, gb,
                 $urandom_range(1, 6));
    end

    send_bit(1'b1, 4, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
